branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the pipelined CPU. Generalises the single-cycle jump/BEQ/BNEQ take-decision into a mode-encoded resolver (J, BEQ, BNEQ, BLT, BGE), and adds a direct-mapped branch target buffer with 2-bit saturating counters. Fetch receives a combinational prediction; execute resolves the branch, updates the table, and raises a registered one-cycle flush with the redirect PC on mispredict.

---
 rtl/branch_predict_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolver (J/BEQ/BNEQ/BLT/BGE) with a direct-mapped, untagged BTB of 2-bit counters.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned INDEX_BITS   = 4,
  parameter int unsigned ALIGN        = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    F_VALID,
  input  logic [PC_WIDTH-1:0]     F_PC,
  output logic                    PRED_TAKEN,
  output logic [PC_WIDTH-1:0]     PRED_TARGET,
  input  logic                    R_VALID,
  input  logic [2:0]              R_MODE,
  input  logic [PC_WIDTH-1:0]     R_PC,
  input  logic [OFFSET_WIDTH-1:0] R_OFFSET,
  input  logic                    R_ZERO,
  input  logic                    R_NEG,
  input  logic                    R_PRED_TAKEN,
  input  logic [PC_WIDTH-1:0]     R_PRED_TARGET,
  output logic                    R_TAKEN,
`ifdef BRANCH_STATS_EN
  output logic [15:0]             BRANCH_COUNT,
  output logic [15:0]             MISPRED_COUNT,
`endif
  output logic                    FLUSH,
  output logic [PC_WIDTH-1:0]     REDIRECT_PC
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(1) << ALIGN;

  localparam logic [2:0] MODE_J    = 3'd1;
  localparam logic [2:0] MODE_BEQ  = 3'd2;
  localparam logic [2:0] MODE_BNEQ = 3'd3;
  localparam logic [2:0] MODE_BLT  = 3'd4;
  localparam logic [2:0] MODE_BGE  = 3'd5;

  typedef struct packed {
    logic                valid;
    logic [1:0]          ctr;
    logic [PC_WIDTH-1:0] target;
  } entry_t;

  entry_t table_q [DEPTH];

  logic                  flush_q;
  logic [PC_WIDTH-1:0]   redirect_q;

  logic [INDEX_BITS-1:0] f_idx;
  logic [INDEX_BITS-1:0] r_idx;
  entry_t                f_entry;
  entry_t                r_entry;

  logic                  decision;
  logic                  is_branch;
  logic                  resolve_en;
  logic                  branch_en;
  logic                  mispredict;
  logic [PC_WIDTH-1:0]   off_ext;
  logic [PC_WIDTH-1:0]   fall_pc;
  logic [PC_WIDTH-1:0]   target_pc;
  logic [PC_WIDTH-1:0]   correct_pc;
  logic [1:0]            ctr_next;

  assign f_idx   = F_PC[ALIGN +: INDEX_BITS];
  assign r_idx   = R_PC[ALIGN +: INDEX_BITS];
  assign f_entry = table_q[f_idx];
  assign r_entry = table_q[r_idx];

  // Fetch-side lookup; reads pre-update table contents.
  assign PRED_TAKEN  = F_VALID & f_entry.valid & f_entry.ctr[1];
  assign PRED_TARGET = PRED_TAKEN ? f_entry.target : F_PC + STEP;

  // Mode decode to take decision.
  always_comb begin
    decision  = 1'b0;
    is_branch = 1'b0;
    case (R_MODE)
      MODE_J:    begin decision = 1'b1;    is_branch = 1'b1; end
      MODE_BEQ:  begin decision = R_ZERO;  is_branch = 1'b1; end
      MODE_BNEQ: begin decision = ~R_ZERO; is_branch = 1'b1; end
      MODE_BLT:  begin decision = R_NEG;   is_branch = 1'b1; end
      MODE_BGE:  begin decision = ~R_NEG;  is_branch = 1'b1; end
      default:   begin decision = 1'b0;    is_branch = 1'b0; end
    endcase
  end

  assign off_ext    = {{(PC_WIDTH-OFFSET_WIDTH){R_OFFSET[OFFSET_WIDTH-1]}}, R_OFFSET};
  assign fall_pc    = R_PC + STEP;
  assign target_pc  = fall_pc + (off_ext << ALIGN);
  assign correct_pc = decision ? target_pc : fall_pc;

  // Inputs during a flush cycle are wrong-path and must be ignored.
  assign resolve_en = R_VALID & ~flush_q;
  assign branch_en  = resolve_en & is_branch;
  assign R_TAKEN    = resolve_en & decision;

  always_comb begin
    mispredict = 1'b0;
    if (branch_en) begin
      mispredict = (decision != R_PRED_TAKEN) |
                   (decision & (R_PRED_TARGET != target_pc));
    end else if (resolve_en) begin
      mispredict = R_PRED_TAKEN;
    end
  end

  // Saturating 2-bit counter step.
  always_comb begin
    ctr_next = r_entry.ctr;
    if (decision && r_entry.ctr != 2'b11) begin
      ctr_next = r_entry.ctr + 2'b01;
    end else if (!decision && r_entry.ctr != 2'b00) begin
      ctr_next = r_entry.ctr - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].ctr    <= 2'b01;
        table_q[i].target <= '0;
      end
    end else if (branch_en) begin
      table_q[r_idx].valid <= 1'b1;
      table_q[r_idx].ctr   <= ctr_next;
      if (decision) begin
        table_q[r_idx].target <= target_pc;
      end
    end
  end

  // Redirect is captured only on a mispredict so it stays stable while FLUSH is high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= correct_pc;
      end
    end
  end

  assign FLUSH       = flush_q;
  assign REDIRECT_PC = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] mispred_cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (branch_en && branch_cnt_q != 16'hFFFF) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
      end
      if (mispredict && mispred_cnt_q != 16'hFFFF) begin
        mispred_cnt_q <= mispred_cnt_q + 16'd1;
      end
    end
  end

  assign BRANCH_COUNT  = branch_cnt_q;
  assign MISPRED_COUNT = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a behavioural table model predicts lookups,
// take decisions and the registered flush/redirect, which are queued and checked a cycle later.
module tb_branch_predict_unit;

  logic        CLK;
  logic        RESET_N;
  logic        F_VALID;
  logic [31:0] F_PC;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        R_VALID;
  logic [2:0]  R_MODE;
  logic [31:0] R_PC;
  logic [7:0]  R_OFFSET;
  logic        R_ZERO;
  logic        R_NEG;
  logic        R_PRED_TAKEN;
  logic [31:0] R_PRED_TARGET;
  logic        R_TAKEN;
  logic        FLUSH;
  logic [31:0] REDIRECT_PC;
`ifdef BRANCH_STATS_EN
  logic [15:0] BRANCH_COUNT;
  logic [15:0] MISPRED_COUNT;
`endif

  branch_predict_unit dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .F_VALID(F_VALID), .F_PC(F_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .R_VALID(R_VALID), .R_MODE(R_MODE), .R_PC(R_PC), .R_OFFSET(R_OFFSET),
    .R_ZERO(R_ZERO), .R_NEG(R_NEG),
    .R_PRED_TAKEN(R_PRED_TAKEN), .R_PRED_TARGET(R_PRED_TARGET),
    .R_TAKEN(R_TAKEN),
`ifdef BRANCH_STATS_EN
    .BRANCH_COUNT(BRANCH_COUNT), .MISPRED_COUNT(MISPRED_COUNT),
`endif
    .FLUSH(FLUSH), .REDIRECT_PC(REDIRECT_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        flush;
    logic [31:0] redirect;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        m_valid [16];
  logic [1:0]  m_ctr   [16];
  logic [31:0] m_tgt   [16];
  logic        m_flush;
  logic [31:0] m_redirect;
  int          m_bc;
  int          m_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic take_of(input logic [2:0] md, input logic z, input logic n);
    case (md)
      3'd1:    return 1'b1;
      3'd2:    return z;
      3'd3:    return !z;
      3'd4:    return n;
      3'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] pc, input logic [7:0] off);
    logic [31:0] sext;
    sext = {{24{off[7]}}, off};
    return pc + 32'd4 + (sext << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
      m_tgt[i]   = 32'd0;
    end
    m_flush    = 1'b0;
    m_redirect = 32'd0;
    m_bc       = 0;
    m_mc       = 0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after posedge.
  task automatic cycle(input logic fv, input logic [31:0] fpc,
                       input logic rv, input logic [2:0] md, input logic [31:0] rpc,
                       input logic [7:0] off, input logic z, input logic n,
                       input logic pt, input logic [31:0] ptg);
    logic [3:0]  fi;
    logic [3:0]  ri;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        eff;
    logic        br;
    logic        d;
    logic        mis;
    logic [31:0] tgt;
    exp_t        e;
    exp_t        got;
    @(negedge CLK);
    F_VALID = fv; F_PC = fpc;
    R_VALID = rv; R_MODE = md; R_PC = rpc; R_OFFSET = off;
    R_ZERO = z; R_NEG = n; R_PRED_TAKEN = pt; R_PRED_TARGET = ptg;
    #1;
    fi    = fpc[5:2];
    e_pt  = fv && m_valid[fi] && m_ctr[fi][1];
    e_ptg = e_pt ? m_tgt[fi] : fpc + 32'd4;
    check("pred_taken", 32'(PRED_TAKEN), 32'(e_pt));
    check("pred_target", PRED_TARGET, e_ptg);
    eff = rv && !m_flush;
    d   = take_of(md, z, n);
    br  = eff && (md >= 3'd1) && (md <= 3'd5);
    tgt = tgt_of(rpc, off);
    check("r_taken", 32'(R_TAKEN), 32'(eff && d));
    if (br) mis = (d != pt) || (d && (ptg != tgt));
    else    mis = eff && pt;
    e.flush    = mis;
    e.redirect = mis ? (d ? tgt : rpc + 32'd4) : m_redirect;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (br) begin
      ri = rpc[5:2];
      m_valid[ri] = 1'b1;
      if (d && m_ctr[ri] != 2'b11) m_ctr[ri] = m_ctr[ri] + 2'b01;
      else if (!d && m_ctr[ri] != 2'b00) m_ctr[ri] = m_ctr[ri] - 2'b01;
      if (d) m_tgt[ri] = tgt;
      if (m_bc < 65535) m_bc++;
    end
    if (mis && m_mc < 65535) m_mc++;
    m_flush = mis;
    if (mis) m_redirect = e.redirect;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("flush", 32'(FLUSH), 32'(got.flush));
      if (got.flush) check("redirect_pc", REDIRECT_PC, got.redirect);
    end
`ifdef BRANCH_STATS_EN
    check("branch_count", 32'(BRANCH_COUNT), 32'(m_bc));
    check("mispred_count", 32'(MISPRED_COUNT), 32'(m_mc));
`endif
  endtask

  task automatic idle(input logic [31:0] fpc);
    cycle(1'b1, fpc, 1'b0, 3'd0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [7:0]  off;
    logic [2:0]  md;
    RESET_N = 1'b0; F_VALID = 1'b1; F_PC = 32'h40;
    R_VALID = 1'b0; R_MODE = 3'd0; R_PC = 32'd0; R_OFFSET = 8'd0;
    R_ZERO = 1'b0; R_NEG = 1'b0; R_PRED_TAKEN = 1'b0; R_PRED_TARGET = 32'd0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    check("rst_flush", 32'(FLUSH), 32'd0);
    check("rst_redirect", REDIRECT_PC, 32'd0);
    check("rst_pred_taken", 32'(PRED_TAKEN), 32'd0);
    check("rst_pred_target", PRED_TARGET, 32'h44);
    @(negedge CLK);
    RESET_N = 1'b1;

    idle(32'h40);
    // BEQ taken, predicted not-taken -> flush to 0x50
    cycle(1'b1, 32'h40, 1'b1, 3'd2, 32'h40, 8'h03, 1'b1, 1'b0, 1'b0, 32'd0);
    // wrong-path resolve during flush: ignored
    cycle(1'b1, 32'h40, 1'b1, 3'd2, 32'h40, 8'h03, 1'b0, 1'b0, 1'b1, 32'h50);
    idle(32'h40);
    check("beq_learned_target", PRED_TARGET, 32'h50);

    // BNEQ backward, predicted correctly, counter saturates
    repeat (4) cycle(1'b1, 32'h80, 1'b1, 3'd3, 32'h80, 8'hFE, 1'b0, 1'b0, 1'b1, 32'h7C);
    cycle(1'b1, 32'h80, 1'b1, 3'd3, 32'h80, 8'hFE, 1'b1, 1'b0, 1'b1, 32'h7C);
    idle(32'h80);
    check("bneq_sat_still_taken", 32'(PRED_TAKEN), 32'd1);

    // BLT not taken but predicted taken; resolve during flush ignored
    cycle(1'b1, 32'hC0, 1'b1, 3'd4, 32'hC0, 8'h10, 1'b0, 1'b0, 1'b1, 32'h104);
    cycle(1'b1, 32'h14, 1'b1, 3'd5, 32'h14, 8'h10, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(32'h14);

    // same-cycle lookup/update of index 5
    cycle(1'b1, 32'h14, 1'b1, 3'd1, 32'h14, 8'h10, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(32'h14);
    check("idx5_new_target", PRED_TARGET, 32'h58);

    // reserved mode predicted taken -> redirect to fall-through
    cycle(1'b1, 32'h20, 1'b1, 3'd6, 32'h200, 8'h05, 1'b1, 1'b1, 1'b1, 32'h300);
    idle(32'h20);
    // target wraps modulo 2^32
    cycle(1'b1, 32'h0, 1'b1, 3'd1, 32'hFFFF_FFF8, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(32'hFFFF_FFF8);

    // random traffic against the model
    for (int k = 0; k < 60; k++) begin
      rpc = 32'($urandom_range(0, 63)) << 2;
      off = 8'($urandom_range(0, 255));
      md  = 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
            1'($urandom_range(0, 3) != 0), md, rpc, off,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? tgt_of(rpc, off) : 32'($urandom));
    end

    // reset asserted while FLUSH is high
    idle(32'h40);
    cycle(1'b1, 32'h40, 1'b1, 3'd1, 32'h40, 8'h07, 1'b0, 1'b0, 1'b0, 32'd0);
    check("pre_reset_flush", 32'(FLUSH), 32'd1);
    @(negedge CLK);
    RESET_N = 1'b0; F_VALID = 1'b1; F_PC = 32'h40; R_VALID = 1'b0;
    #1;
    model_reset();
    check("midflush_rst_flush", 32'(FLUSH), 32'd0);
    check("midflush_rst_redirect", REDIRECT_PC, 32'd0);
    check("midflush_rst_pred", 32'(PRED_TAKEN), 32'd0);
`ifdef BRANCH_STATS_EN
    check("midflush_rst_bc", 32'(BRANCH_COUNT), 32'd0);
    check("midflush_rst_mc", 32'(MISPRED_COUNT), 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(32'h40);
    cycle(1'b1, 32'h40, 1'b1, 3'd5, 32'h40, 8'h02, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
